conv_tile_controller: RTL

Sequencer for the 3x3 systolic convolution array (4x4 8-bit image window, 3x3 8-bit filter, 2x2 8-bit result). It holds the image and filter operands in a local byte-addressed register file loaded over a valid/ready port. On `start` it pulses the array's active-high reset, waits a fixed compute latency, then captures the four results with a `done` pulse. It sits between the host/DMA side and the array, so the array never sees operands changing mid-computation.

---
 rtl/conv_tile_controller_if.sv | 22 ++
 rtl/conv_tile_controller.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/conv_tile_controller_if.sv
// Operand load port: byte writes into the tile register file.
// master drives ld_valid/ld_addr/ld_data, slave returns ld_ready.
interface conv_tile_controller_if;
  logic       ld_valid;
  logic       ld_ready;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;

  modport master (
    output ld_valid,
    output ld_addr,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/conv_tile_controller.sv
// conv_tile_controller: sequencer for the 3x3 systolic conv array.
// Holds image/filter bytes, resets the array, waits LATENCY, captures.
// Ports: clk, rst (async, active-low), ld (load port, slave),
//   start/busy/done, result[31:0],
//   arr_rst/arr_img[127:0]/arr_flt[71:0] to the array, arr_out[31:0].
// Optional: LOAD_CHECK_EN gates start on all 25 operands written.
module conv_tile_controller #(
  parameter int RST_CYC = 2,
  parameter int LATENCY = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  conv_tile_controller_if.slave        ld,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  result,
  output logic                         arr_rst,
  output logic [127:0]                 arr_img,
  output logic [71:0]                  arr_flt,
  input  logic [31:0]                  arr_out
);

  typedef enum logic [1:0] {
    IDLE,
    ARST,
    RUN,
    CAPT
  } state_t;

  localparam logic [4:0] RST_LD = 5'(RST_CYC - 1);
  localparam logic [4:0] LAT_LD = 5'(LATENCY - 1);

  state_t       st;
  logic [4:0]   cnt;
  logic         rdy_q;
  logic [127:0] img_q;
  logic [71:0]  flt_q;
  logic         wr;
  logic         wr_img;
  logic         wr_flt;
  logic         go;

  assign ld.ld_ready = rdy_q;
  assign arr_img     = img_q;
  assign arr_flt     = flt_q;
  assign wr          = ld.ld_valid && rdy_q;

  // Addresses 25..31 fall through to default: acked, dropped.
  always_comb begin
    wr_img = 1'b0;
    wr_flt = 1'b0;
    unique case (1'b1)
      (wr && !ld.ld_addr[4]):
        wr_img = 1'b1;
      (wr && ld.ld_addr[4] && (ld.ld_addr <= 5'd24)):
        wr_flt = 1'b1;
      default: ;
    endcase
  end

`ifdef LOAD_CHECK_EN
  logic [24:0] mask_q;

  assign go = start && (&mask_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else if (st == CAPT) begin
      mask_q <= '0;
    end else if (wr_img || wr_flt) begin
      mask_q[ld.ld_addr] <= 1'b1;
    end
  end
`else
  assign go = start;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_q <= '0;
      flt_q <= '0;
    end else begin
      if (wr_img)
        img_q[{ld.ld_addr[3:0], 3'b000} +: 8] <= ld.ld_data;
      if (wr_flt)
        flt_q[{ld.ld_addr[3:0], 3'b000} +: 8] <= ld.ld_data;
    end
  end

  // Outputs are registered alongside the state so each
  // reflects the state it belongs to in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      cnt     <= '0;
      rdy_q   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      arr_rst <= 1'b1;
      result  <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (go) begin
            st      <= ARST;
            cnt     <= RST_LD;
            rdy_q   <= 1'b0;
            busy    <= 1'b1;
            arr_rst <= 1'b1;
          end
        end
        ARST: begin
          if (cnt == 5'd0) begin
            st      <= RUN;
            cnt     <= LAT_LD;
            arr_rst <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RUN: begin
          // Capture on entry so result is valid during CAPT.
          if (cnt == 5'd0) begin
            st     <= CAPT;
            result <= arr_out;
            done   <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        CAPT: begin
          st      <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          rdy_q   <= 1'b1;
          arr_rst <= 1'b1;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule
